// File: rtl/cla_slice_scheduler.sv
// cla_slice_scheduler: time-shares one 8-bit carry-lookahead slice between the
// multiplier (A) and the divider (B). Each add/sub is run low byte first through
// the external slice. The ripple carry between bytes is regenerated here from
// the slice's group propagate/generate outputs.
module cla_slice_scheduler #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  // requester A (multiplier)
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_opa,
  input  logic [WIDTH-1:0] a_opb,
  input  logic             a_sub,
  // requester B (divider)
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_opa,
  input  logic [WIDTH-1:0] b_opb,
  input  logic             b_sub,
  // result channel
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  // shared CLA slice
  output logic [SLICE-1:0] sl_a,
  output logic [SLICE-1:0] sl_b,
  output logic             sl_cin,
  input  logic [SLICE-1:0] sl_s,
  input  logic             sl_p,
  input  logic             sl_g
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;       // operand B already inverted for subtract
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;   // carry into the current byte, final carry in DONE
  logic             id_q, id_d;
  logic             last_q, last_d;     // last granted requester: 0 = A, 1 = B
  logic [CW-1:0]    k_q, k_d;
  logic             ovf_q, ovf_d;
  logic             res_valid_q, res_valid_d;

  logic             grant_a_c;
  logic             grant_b_c;
  logic [WIDTH-1:0] req_opa_c;
  logic [WIDTH-1:0] req_opb_c;
  logic             req_sub_c;
  logic [IW-1:0]    base_c;

  // Round-robin arbitration, only while idle; ties go to the requester not served last
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    if (state_q == S_IDLE) begin
      if (a_valid && (!b_valid || last_q)) begin
        grant_a_c = 1'b1;
      end else if (b_valid) begin
        grant_b_c = 1'b1;
      end
    end
  end

  // Readies follow the grant, forced low while reset is asserted
  always_comb begin
    a_ready = grant_a_c & reset_n;
    b_ready = grant_b_c & reset_n;
  end

  // Operand mux for the granted requester
  always_comb begin
    req_opa_c = grant_b_c ? b_opa : a_opa;
    req_opb_c = grant_b_c ? b_opb : a_opb;
    req_sub_c = grant_b_c ? b_sub : a_sub;
  end

  // Bit offset of the byte currently in the slice
  always_comb begin
    base_c = IW'(k_q) * IW'(SLICE);
  end

  // Drive the slice only while running; zero otherwise
  always_comb begin
    sl_a   = '0;
    sl_b   = '0;
    sl_cin = 1'b0;
    if (state_q == S_RUN) begin
      sl_a   = opa_q[base_c +: SLICE];
      sl_b   = opb_q[base_c +: SLICE];
      sl_cin = carry_q;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    id_d        = id_q;
    last_d      = last_q;
    k_d         = k_q;
    ovf_d       = ovf_q;
    res_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_a_c || grant_b_c) begin
          state_d = S_RUN;
          opa_d   = req_opa_c;
          opb_d   = req_sub_c ? ~req_opb_c : req_opb_c;
          carry_d = req_sub_c;
          id_d    = grant_b_c;
          last_d  = grant_b_c;
          k_d     = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        sum_d[base_c +: SLICE] = sl_s;
        carry_d = sl_g | (sl_p & sl_cin);
        k_d     = k_q + CW'(1);
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          // Signed overflow: like-signed operands producing an opposite-signed sum
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (sum_d[WIDTH-1] != opa_q[WIDTH-1]);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    res_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      k_q         <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      id_q        <= id_d;
      last_q      <= last_d;
      k_q         <= k_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Result outputs come straight from registers, masked outside DONE
  always_comb begin
    res_valid = res_valid_q;
    res_id    = res_valid_q & id_q;
    res_sum   = res_valid_q ? sum_q : '0;
    res_cout  = res_valid_q & carry_q;
    res_ovf   = res_valid_q & ovf_q;
  end

endmodule

// File: tb/tb_cla_slice_scheduler.sv
// Bench for cla_slice_scheduler: behavioural 8-bit CLA slice, directed scenarios
// and a randomized request stream checked against an arithmetic reference model.
module tb_cla_slice_scheduler;

  logic        clock;
  logic        reset_n;
  logic        a_valid, a_ready, a_sub;
  logic [31:0] a_opa, a_opb;
  logic        b_valid, b_ready, b_sub;
  logic [31:0] b_opa, b_opb;
  logic        res_valid, res_ready, res_id, res_cout, res_ovf;
  logic [31:0] res_sum;
  logic [7:0]  sl_a, sl_b, sl_s;
  logic        sl_cin, sl_p, sl_g;

  int total = 0;
  int bad   = 0;

  cla_slice_scheduler #(.WIDTH(32), .SLICE(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opa(a_opa), .a_opb(a_opb), .a_sub(a_sub),
    .b_valid(b_valid), .b_ready(b_ready), .b_opa(b_opa), .b_opb(b_opb), .b_sub(b_sub),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_sum(res_sum),
    .res_cout(res_cout), .res_ovf(res_ovf),
    .sl_a(sl_a), .sl_b(sl_b), .sl_cin(sl_cin), .sl_s(sl_s), .sl_p(sl_p), .sl_g(sl_g)
  );

  // Behavioural CLA slice: sum, group propagate, group generate
  logic [8:0] sl_full, sl_gen;
  assign sl_full = {1'b0, sl_a} + {1'b0, sl_b} + {8'd0, sl_cin};
  assign sl_gen  = {1'b0, sl_a} + {1'b0, sl_b};
  assign sl_s    = sl_full[7:0];
  assign sl_g    = sl_gen[8];
  assign sl_p    = &(sl_a ^ sl_b);

  always #5 clock = ~clock;

  // Reference: {ovf, cout, sum} from plain 32-bit and signed 64-bit arithmetic
  function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y, input bit sub);
    longint sx, sy, sr;
    logic [32:0] u;
    logic cout, ovf;
    logic [31:0] s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sr = sub ? sx - sy : sx + sy;
    u  = {1'b0, x} + {1'b0, y};
    s  = sub ? x - y : x + y;
    cout = sub ? (x >= y) : u[32];
    ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {ovf, cout, s};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Present one request on a single side and wait (bounded) for its acceptance.
  // Returns at the falling edge of the first RUN cycle with valid dropped.
  task automatic issue(input bit side, input logic [31:0] x, input logic [31:0] y,
                       input bit sub, output bit ok);
    int n;
    @(negedge clock);
    if (!side) begin a_valid = 1; a_opa = x; a_opb = y; a_sub = sub; end
    else       begin b_valid = 1; b_opa = x; b_opb = y; b_sub = sub; end
    ok = 0;
    n  = 0;
    while (!ok && n < 20) begin
      #1;
      if ((side ? b_ready : a_ready) === 1'b1) ok = 1;
      else begin @(negedge clock); n++; end
    end
    @(posedge clock);
    @(negedge clock);
    if (!side) a_valid = 0; else b_valid = 0;
  endtask

  // Wait (bounded) for a result, sample it, then complete the handshake after
  // 'hold' extra cycles. Starts in the first RUN cycle (lat = 1).
  task automatic collect(input int hold, output int lat, output logic [31:0] s,
                         output logic c, output logic o, output logic id, output bit ok);
    lat = 1;
    while (res_valid !== 1'b1 && lat < 20) begin @(negedge clock); lat++; end
    ok = (res_valid === 1'b1);
    s = res_sum; c = res_cout; o = res_ovf; id = res_id;
    repeat (hold) @(negedge clock);
    res_ready = 1;
    @(negedge clock);
    res_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    a_valid = 1; b_valid = 1;
    #1;
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b want=0", a_ready); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL reset_b_ready got=%b want=0", b_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    total++; if ({res_sum, res_cout, res_ovf, res_id} !== 35'd0) begin bad++; $display("FAIL reset_res got=%h want=0", {res_sum, res_cout, res_ovf, res_id}); end
    total++; if ({sl_a, sl_b, sl_cin} !== 17'd0) begin bad++; $display("FAIL reset_slice got=%h want=0", {sl_a, sl_b, sl_cin}); end
    a_valid = 0; b_valid = 0;
    reset_n = 1;
    @(negedge clock); #1;
    total++; if ({a_ready, b_ready, res_valid} !== 3'b000) begin bad++; $display("FAIL idle_after_reset got=%b want=000", {a_ready, b_ready, res_valid}); end
  endtask

  task automatic test_directed();
    bit ok, ok2; int lat; logic [31:0] s; logic c, o, id;
    // A: 0xFF + 1
    issue(0, 32'h0000_00FF, 32'h0000_0001, 0, ok);
    collect(0, lat, s, c, o, id, ok2);
    total++; if (!(ok && ok2) || lat != 5) begin bad++; $display("FAIL t1_latency got=%0d want=5 ok=%b%b", lat, ok, ok2); end
    total++; if ({s, c, o, id} !== {32'h0000_0100, 3'b000}) begin bad++; $display("FAIL t1_result got=%h/%b%b%b want=00000100/000", s, c, o, id); end
    // B: 5 - 7
    issue(1, 32'h0000_0005, 32'h0000_0007, 1, ok);
    total++; if ({sl_a, sl_b, sl_cin} !== {8'h05, 8'hF8, 1'b1}) begin bad++; $display("FAIL t2_first_run got=%h %h %b want=05 f8 1", sl_a, sl_b, sl_cin); end
    collect(0, lat, s, c, o, id, ok2);
    total++; if (!(ok && ok2) || lat != 5) begin bad++; $display("FAIL t2_latency got=%0d want=5 ok=%b%b", lat, ok, ok2); end
    total++; if ({s, c, o, id} !== {32'hFFFF_FFFE, 3'b001}) begin bad++; $display("FAIL t2_result got=%h/%b%b%b want=fffffffe/001", s, c, o, id); end
    // A: 0x7FFFFFFF + 1 overflows
    issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 0, ok);
    collect(0, lat, s, c, o, id, ok2);
    total++; if (!(ok && ok2) || {s, c, o, id} !== {32'h8000_0000, 3'b010}) begin bad++; $display("FAIL t3_ovf got=%h/%b%b%b want=80000000/010", s, c, o, id); end
    // A: 0xFFFFFFFF + 1 carries out
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 0, ok);
    collect(0, lat, s, c, o, id, ok2);
    total++; if (!(ok && ok2) || {s, c, o, id} !== {32'h0000_0000, 3'b100}) begin bad++; $display("FAIL t3_cout got=%h/%b%b%b want=00000000/100", s, c, o, id); end
  endtask

  task automatic test_round_robin();
    int gseq[$]; int gcyc[$]; int idseq[$]; logic [31:0] sums[$];
    bit both;
    both = 0;
    // Reset this block to give last_grant = B before both requesters go valid
    @(negedge clock); reset_n = 0;
    @(negedge clock); reset_n = 1;
    a_valid = 1; a_opa = 32'h10;  a_opb = 32'h20; a_sub = 0;
    b_valid = 1; b_opa = 32'h100; b_opb = 32'h1;  b_sub = 1;
    res_ready = 1;
    for (int c = 0; c < 26; c++) begin
      #1;
      if (a_ready && b_ready) both = 1;
      if (a_ready === 1'b1) begin gseq.push_back(0); gcyc.push_back(c); end
      if (b_ready === 1'b1) begin gseq.push_back(1); gcyc.push_back(c); end
      if (res_valid === 1'b1) begin idseq.push_back(int'(res_id)); sums.push_back(res_sum); end
      @(negedge clock);
    end
    a_valid = 0; b_valid = 0;
    repeat (8) @(negedge clock);
    res_ready = 0;
    total++; if (both) begin bad++; $display("FAIL rr_two_readies got=1 want=0"); end
    total++; if (gseq.size() != 5) begin bad++; $display("FAIL rr_grant_count got=%0d want=5", gseq.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= gseq.size() || gseq[i] != i % 2 || gcyc[i] != 6 * i) begin
        bad++; $display("FAIL rr_grant%0d got=%0d@%0d want=%0d@%0d", i,
                        (i < gseq.size()) ? gseq[i] : -1, (i < gcyc.size()) ? gcyc[i] : -1, i % 2, 6 * i);
      end
      total++;
      if (i >= idseq.size() || idseq[i] != i % 2 || sums[i] !== ((i % 2) ? 32'h0000_00FF : 32'h0000_0030)) begin
        bad++; $display("FAIL rr_result%0d got_id=%0d got_sum=%h want_id=%0d", i,
                        (i < idseq.size()) ? idseq[i] : -1, (i < sums.size()) ? sums[i] : 32'h0, i % 2);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, ok2; int n, lat; logic [31:0] s; logic c, o, id;
    issue(0, 32'h1234_5678, 32'h1111_1111, 0, ok);
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    total++; if (!ok || n != 4) begin bad++; $display("FAIL bp_reach_done got=%0d want=4 ok=%b", n, ok); end
    b_valid = 1; b_opa = 32'h3; b_opb = 32'h4; b_sub = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({res_valid, res_sum, res_cout, res_ovf, res_id, a_ready, b_ready} !== {1'b1, 32'h2345_6789, 5'b00000}) begin
        bad++; $display("FAIL bp_hold%0d got=%b %h %b%b%b rdy=%b%b want=1 23456789 000 rdy=00",
                        i, res_valid, res_sum, res_cout, res_ovf, res_id, a_ready, b_ready);
      end
      @(negedge clock);
    end
    res_ready = 1;
    @(negedge clock);
    res_ready = 0;
    #1;
    total++; if ({res_valid, b_ready} !== 2'b01) begin bad++; $display("FAIL bp_idle_after got=%b%b want=01", res_valid, b_ready); end
    @(posedge clock);
    @(negedge clock);
    b_valid = 0;
    collect(0, lat, s, c, o, id, ok2);
    total++; if (!ok2 || lat != 5 || {s, c, o, id} !== {32'h7, 3'b001}) begin bad++; $display("FAIL bp_next got=%h/%b%b%b lat=%0d want=00000007/001 lat=5", s, c, o, id, lat); end
  endtask

  task automatic test_reset_mid_run();
    bit ok, ok2, seen; int lat; logic [31:0] s; logic c, o, id;
    issue(0, 32'h0000_AAAA, 32'h0000_5555, 0, ok);
    @(negedge clock);
    a_valid = 1; a_opa = 32'h1; a_opb = 32'h2; a_sub = 0;
    b_valid = 1; b_opa = 32'h9; b_opb = 32'h4; b_sub = 1;
    reset_n = 0;
    #1;
    total++;
    if ({sl_a, sl_b, sl_cin, res_valid, res_sum, a_ready, b_ready} !== 52'd0) begin
      bad++; $display("FAIL mid_reset_outputs got=%h %h %b %b %h %b%b want=0", sl_a, sl_b, sl_cin, res_valid, res_sum, a_ready, b_ready);
    end
    a_valid = 0; b_valid = 0;
    @(negedge clock);
    reset_n = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin #1; if (res_valid !== 1'b0) seen = 1; @(negedge clock); end
    total++; if (seen) begin bad++; $display("FAIL mid_reset_no_result got=1 want=0"); end
    a_valid = 1; b_valid = 1;
    #1;
    total++; if ({a_ready, b_ready} !== 2'b10) begin bad++; $display("FAIL mid_reset_grant got=%b%b want=10", a_ready, b_ready); end
    @(posedge clock);
    @(negedge clock);
    a_valid = 0;
    collect(0, lat, s, c, o, id, ok2);
    total++; if (!(ok && ok2) || {s, c, o, id} !== {32'h3, 3'b000}) begin bad++; $display("FAIL mid_reset_a got=%h/%b%b%b want=00000003/000", s, c, o, id); end
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_b_ready got=%b want=1", b_ready); end
    @(posedge clock);
    @(negedge clock);
    b_valid = 0;
    collect(0, lat, s, c, o, id, ok2);
    total++; if (!ok2 || {s, c, o, id} !== {32'h5, 3'b101}) begin bad++; $display("FAIL mid_reset_b got=%h/%b%b%b want=00000005/101", s, c, o, id); end
  endtask

  task automatic test_random();
    bit pend[2]; logic [31:0] ox[2]; logic [31:0] oy[2]; bit osub[2];
    bit model_last, exp_side, ok, fs; int lat; logic [31:0] s; logic c, o, id; logic [33:0] e;
    @(negedge clock); reset_n = 0;
    @(negedge clock); reset_n = 1;
    model_last = 1;
    pend[0] = 0; pend[1] = 0;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k]) begin
          ox[k] = pick(); oy[k] = pick(); osub[k] = bit'($urandom_range(0, 1));
          pend[k] = ($urandom_range(0, 2) != 0);
        end
      end
      fs = bit'($urandom_range(0, 1));
      if (!pend[0] && !pend[1]) pend[fs] = 1;
      a_valid = pend[0]; a_opa = ox[0]; a_opb = oy[0]; a_sub = osub[0];
      b_valid = pend[1]; b_opa = ox[1]; b_opb = oy[1]; b_sub = osub[1];
      exp_side = (pend[0] && pend[1]) ? !model_last : pend[1];
      #1;
      total++;
      if ({a_ready, b_ready} !== {!exp_side, exp_side}) begin
        bad++; $display("FAIL rnd%0d_grant got=%b%b want=%b%b", it, a_ready, b_ready, !exp_side, exp_side);
      end
      @(posedge clock);
      @(negedge clock);
      if (!exp_side) a_valid = 0; else b_valid = 0;
      pend[exp_side] = 0;
      model_last = exp_side;
      e = ref_op(ox[exp_side], oy[exp_side], osub[exp_side]);
      collect($urandom_range(0, 2), lat, s, c, o, id, ok);
      total++; if (!ok || lat != 5) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=5", it, lat); end
      total++; if (id !== exp_side) begin bad++; $display("FAIL rnd%0d_id got=%b want=%b", it, id, exp_side); end
      total++;
      if ({o, c, s} !== e) begin
        bad++; $display("FAIL rnd%0d_result op=%h %s %h got=%h/c%b/v%b want=%h/c%b/v%b", it,
                        ox[exp_side], osub[exp_side] ? "-" : "+", oy[exp_side], s, c, o, e[31:0], e[32], e[33]);
      end
    end
    a_valid = 0; b_valid = 0;
  endtask

  initial begin
    clock = 0; reset_n = 0;
    a_valid = 0; a_opa = '0; a_opb = '0; a_sub = 0;
    b_valid = 0; b_opa = '0; b_opb = '0; b_sub = 0;
    res_ready = 0;
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
